// File: rtl/wb_sram_slave_pkg.sv
// Shared types and helpers for the Wishbone-to-16-bit-SRAM word bridge.
package wb_sram_slave_pkg;

    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned WAIT_CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_ACK
    } state_t;

    // Byte selects for one half: half 0 is the upper (big-endian first) half-word.
    function automatic logic [1:0] lane_sel(input logic [3:0] sel, input logic half);
        return half ? sel[1:0] : sel[3:2];
    endfunction

    // Write data for one half, same lane ordering as lane_sel.
    function automatic logic [SRAM_DW-1:0] lane_dat(input logic [31:0] dat, input logic half);
        return half ? dat[15:0] : dat[31:16];
    endfunction

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone classic slave-side bus bundle for wb_sram_slave.
interface wb_sram_slave_if;

    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr;
    logic [31:0] s_dat_i;
    logic [31:0] s_dat_o;
    logic        s_ack;

    modport master (
        output s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_i,
        input  s_dat_o, s_ack
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_i,
        output s_dat_o, s_ack
    );

endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave serving 32-bit words from an external async 16-bit SRAM,
// two half-word SRAM cycles per word with programmable wait states.
module wb_sram_slave
    import wb_sram_slave_pkg::*;
#(
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                sys_clk,
    input  logic                nreset,
    wb_sram_slave_if.slave      wb,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_o,
    input  logic [SRAM_DW-1:0]  sram_dq_i,
    output logic                sram_dq_oe,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
);

    localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(WAIT_STATES);

    state_t               state_q, state_d;
    logic                 half_q, half_d;
    logic                 pend_q, pend_d;
    logic [WAIT_CW-1:0]   wcnt_q, wcnt_d;
    logic [SRAM_AW-2:0]   adr_q, adr_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          dat_q, dat_d;

    logic [31:0]          dat_o_d;
    logic                 ack_d;
    logic [SRAM_AW-1:0]   addr_d;
    logic [SRAM_DW-1:0]   dq_o_d;
    logic                 dq_oe_d;
    logic                 ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;

    logic                 launch;
    logic                 launch_half;
    logic [1:0]           launch_sel;

    logic                 unused_adr;
    assign unused_adr = ^{wb.s_adr[31:SRAM_AW+1], wb.s_adr[1:0]};

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        pend_d      = pend_q;
        wcnt_d      = wcnt_q;
        adr_d       = adr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        dat_o_d     = wb.s_dat_o;
        ack_d       = 1'b0;
        addr_d      = sram_addr;
        dq_o_d      = sram_dq_o;
        dq_oe_d     = sram_dq_oe;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        ub_n_d      = sram_ub_n;
        lb_n_d      = sram_lb_n;
        launch      = 1'b0;
        launch_half = 1'b0;
        launch_sel  = 2'b00;

        if (state_q != ST_IDLE && !wb.s_cyc) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            dq_oe_d = 1'b0;
            ub_n_d  = 1'b1;
            lb_n_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wb.s_cyc && wb.s_stb) begin
                        adr_d = wb.s_adr[SRAM_AW:2];
                        we_d  = wb.s_we;
                        sel_d = wb.s_sel;
                        dat_d = wb.s_dat_i;
                        if (!wb.s_we) begin
                            launch      = 1'b1;
                            launch_half = 1'b0;
                            pend_d      = 1'b1;
                        end else if (wb.s_sel[3:2] != 2'b00) begin
                            launch      = 1'b1;
                            launch_half = 1'b0;
                            pend_d      = (wb.s_sel[1:0] != 2'b00);
                        end else if (wb.s_sel[1:0] != 2'b00) begin
                            launch      = 1'b1;
                            launch_half = 1'b1;
                            pend_d      = 1'b0;
                        end else begin
                            state_d = ST_ACK;
                            ack_d   = 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    state_d = ST_STROBE;
                    wcnt_d  = '0;
                    ce_n_d  = 1'b0;
                    oe_n_d  = we_q;
                    we_n_d  = ~we_q;
                end
                ST_STROBE: begin
                    if (wcnt_q == WAIT_LAST) begin
                        if (!we_q) begin
                            if (half_q) dat_o_d[15:0]  = sram_dq_i;
                            else        dat_o_d[31:16] = sram_dq_i;
                        end
                        dq_oe_d = 1'b0;
                        if (pend_q) begin
                            pend_d      = 1'b0;
                            launch      = 1'b1;
                            launch_half = 1'b1;
                        end else begin
                            state_d = ST_ACK;
                            ack_d   = 1'b1;
                            ub_n_d  = 1'b1;
                            lb_n_d  = 1'b1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + WAIT_CW'(1);
                        ce_n_d = 1'b0;
                        oe_n_d = we_q;
                        we_n_d = ~we_q;
                    end
                end
                ST_ACK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Shared entry into SETUP for either half, from IDLE or from the end of a STROBE.
        if (launch) begin
            state_d    = ST_SETUP;
            half_d     = launch_half;
            addr_d     = {adr_d, launch_half};
            launch_sel = we_d ? lane_sel(sel_d, launch_half) : 2'b11;
            ub_n_d     = ~launch_sel[1];
            lb_n_d     = ~launch_sel[0];
            dq_oe_d    = we_d;
            if (we_d) dq_o_d = lane_dat(dat_d, launch_half);
        end
    end

    // State, request latches and registered outputs.
    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            half_q      <= 1'b0;
            pend_q      <= 1'b0;
            wcnt_q      <= '0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            dat_q       <= '0;
            wb.s_dat_o  <= '0;
            wb.s_ack    <= 1'b0;
            sram_addr   <= '0;
            sram_dq_o   <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            pend_q      <= pend_d;
            wcnt_q      <= wcnt_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            wb.s_dat_o  <= dat_o_d;
            wb.s_ack    <= ack_d;
            sram_addr   <= addr_d;
            sram_dq_o   <= dq_o_d;
            sram_dq_oe  <= dq_oe_d;
            sram_ce_n   <= ce_n_d;
            sram_oe_n   <= oe_n_d;
            sram_we_n   <= we_n_d;
            sram_ub_n   <= ub_n_d;
            sram_lb_n   <= lb_n_d;
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: word-level reference memory, pin-level SRAM models,
// one DUT with one wait state and one with none.
module tb_wb_sram_slave;

    localparam int unsigned AW = 18;

    logic sys_clk = 1'b0;
    logic nreset  = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int unsigned cycle = 0;
    always @(posedge sys_clk) cycle <= cycle + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    wb_sram_slave_if bus();
    wb_sram_slave_if bus_w0();

    logic [AW-1:0] sram_addr, sram_addr_w0;
    logic [15:0]   sram_dq_o, sram_dq_i, sram_dq_o_w0, sram_dq_i_w0;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic          sram_dq_oe_w0, sram_ce_n_w0, sram_oe_n_w0, sram_we_n_w0, sram_ub_n_w0, sram_lb_n_w0;

    wb_sram_slave #(.SRAM_AW(AW), .WAIT_STATES(1)) dut (
        .sys_clk(sys_clk), .nreset(nreset), .wb(bus),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    wb_sram_slave #(.SRAM_AW(AW), .WAIT_STATES(0)) dut_w0 (
        .sys_clk(sys_clk), .nreset(nreset), .wb(bus_w0),
        .sram_addr(sram_addr_w0), .sram_dq_o(sram_dq_o_w0), .sram_dq_i(sram_dq_i_w0),
        .sram_dq_oe(sram_dq_oe_w0), .sram_ce_n(sram_ce_n_w0), .sram_oe_n(sram_oe_n_w0),
        .sram_we_n(sram_we_n_w0), .sram_ub_n(sram_ub_n_w0), .sram_lb_n(sram_lb_n_w0)
    );

    // ---------------- pin-level SRAM models ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we_n;
        logic          oe_n;
        logic          ub_n;
        logic          lb_n;
    } acc_t;

    logic [15:0] sram    [0:(1<<AW)-1];
    logic [15:0] sram_w0 [0:(1<<AW)-1];
    acc_t        acc_log[$];
    acc_t        exp_acc[$];
    logic        ce_prev = 1'b1;

    assign sram_dq_i    = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'hA5C3;
    assign sram_dq_i_w0 = (!sram_ce_n_w0 && !sram_oe_n_w0) ? sram_w0[sram_addr_w0] : 16'hA5C3;

    // SRAM array writes and a log of every strobe start on the W=1 device.
    always @(posedge sys_clk) begin
        if (!sram_ce_n && ce_prev)
            acc_log.push_back(acc_t'({sram_addr, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}));
        ce_prev <= sram_ce_n;
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) sram[sram_addr][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) sram[sram_addr][7:0]  <= sram_dq_o[7:0];
        end
    end

    // SRAM array writes on the W=0 device.
    always @(posedge sys_clk) begin
        if (!sram_ce_n_w0 && !sram_we_n_w0) begin
            if (!sram_ub_n_w0) sram_w0[sram_addr_w0][15:8] <= sram_dq_o_w0[15:8];
            if (!sram_lb_n_w0) sram_w0[sram_addr_w0][7:0]  <= sram_dq_o_w0[7:0];
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int unsigned cyc;
        logic        rd;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb_w0[$];
    exp_t        mon_e;
    exp_t        mon_e_w0;
    logic [31:0] ref_mem [2][64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] w;
        w = old;
        for (int unsigned b = 0; b < 4; b++)
            if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    // Request-to-ack latency from the number of half-words an access touches.
    function automatic int unsigned exp_latency(input logic we, input logic [3:0] sel, input int unsigned ws);
        int unsigned halves;
        if (!we) halves = 2;
        else     halves = ((sel[3:2] != 2'b00) ? 1 : 0) + ((sel[1:0] != 2'b00) ? 1 : 0);
        if (halves == 0) return 1;
        if (halves == 1) return 3 + ws;
        return 5 + 2 * ws;
    endfunction

    // Ack monitor for the W=1 device, plus bus-level control invariants.
    always @(negedge sys_clk) begin
        if (bus.s_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(bus.s_ack), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_cycle", cycle, mon_e.cyc);
                if (mon_e.rd) check("read_data", bus.s_dat_o, mon_e.dat);
            end
        end
        if (!sram_we_n || !sram_oe_n) check("we_oe_exclusive", 32'(sram_we_n | sram_oe_n), 32'd1);
        if (!sram_we_n) check("dq_oe_during_write", 32'(sram_dq_oe), 32'd1);
    end

    // Ack monitor for the W=0 device.
    always @(negedge sys_clk) begin
        if (bus_w0.s_ack) begin
            if (sb_w0.size() == 0) begin
                check("w0_unexpected_ack", 32'(bus_w0.s_ack), 32'd0);
            end else begin
                mon_e_w0 = sb_w0.pop_front();
                check("w0_ack_cycle", cycle, mon_e_w0.cyc);
                if (mon_e_w0.rd) check("w0_read_data", bus_w0.s_dat_o, mon_e_w0.dat);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit w0, input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        if (w0) begin
            bus_w0.s_cyc = cyc; bus_w0.s_stb = stb; bus_w0.s_we = we;
            bus_w0.s_sel = sel; bus_w0.s_adr = adr; bus_w0.s_dat_i = dat;
        end else begin
            bus.s_cyc = cyc; bus.s_stb = stb; bus.s_we = we;
            bus.s_sel = sel; bus.s_adr = adr; bus.s_dat_i = dat;
        end
    endtask

    task automatic wb_xfer(input bit w0, input logic we, input int unsigned idx, input logic [3:0] sel,
                           input logic [31:0] dat, input int unsigned stb_gap);
        exp_t        e;
        bit          got;
        logic [31:0] adr;
        adr = 32'(idx) << 2;
        @(posedge sys_clk);
        #1;
        if (stb_gap != 0) begin
            drive(w0, 1'b1, 1'b0, we, sel, adr, dat);
            repeat (stb_gap) @(posedge sys_clk);
            #1;
        end
        drive(w0, 1'b1, 1'b1, we, sel, adr, dat);
        e.cyc = cycle + exp_latency(we, sel, w0 ? 0 : 1);
        e.rd  = !we;
        e.dat = ref_mem[w0][idx];
        if (we) ref_mem[w0][idx] = merge(ref_mem[w0][idx], dat, sel);
        if (w0) sb_w0.push_back(e);
        else    sb.push_back(e);
        got = 1'b0;
        for (int unsigned i = 0; i < 64 && !got; i++) begin
            @(posedge sys_clk);
            #1;
            got = w0 ? bus_w0.s_ack : bus.s_ack;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=no_ack required=ack (unit %0d idx %0d)", w0, idx);
        end
        drive(w0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, 32'(acc_log.size()), 32'(exp_acc.size()));
        while (acc_log.size() != 0 && exp_acc.size() != 0)
            check(name, 32'(acc_log.pop_front()), 32'(exp_acc.pop_front()));
        acc_log.delete();
        exp_acc.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ce_n"},  32'(sram_ce_n),  32'd1);
        check({tag, "_oe_n"},  32'(sram_oe_n),  32'd1);
        check({tag, "_we_n"},  32'(sram_we_n),  32'd1);
        check({tag, "_ub_n"},  32'(sram_ub_n),  32'd1);
        check({tag, "_lb_n"},  32'(sram_lb_n),  32'd1);
        check({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
        check({tag, "_ack"},   32'(bus.s_ack),  32'd0);
        check({tag, "_dat_o"}, bus.s_dat_o,     32'd0);
        check({tag, "_addr"},  32'(sram_addr),  32'd0);
        check({tag, "_dq_o"},  32'(sram_dq_o),  32'd0);
    endtask

    // Start a read and return once its first strobe is on the pins.
    task automatic start_read_to_strobe(input string tag);
        bit seen;
        @(posedge sys_clk);
        #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        seen = 1'b0;
        for (int unsigned i = 0; i < 20 && !seen; i++) begin
            @(posedge sys_clk);
            #1;
            seen = !sram_ce_n;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_strobe_timeout actual=no_strobe required=strobe", tag);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : main
        for (int unsigned u = 0; u < 2; u++)
            for (int unsigned i = 0; i < 64; i++)
                ref_mem[u][i] = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nreset = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_vals("por");
        nreset = 1'b1;

        // Full-word write then read, one wait state.
        acc_log.delete();
        wb_xfer(1'b0, 1'b1, 4, 4'hF, 32'hDEADBEEF, 0);
        exp_acc.push_back(acc_t'({18'h8, 1'b0, 1'b1, 1'b0, 1'b0}));
        exp_acc.push_back(acc_t'({18'h9, 1'b0, 1'b1, 1'b0, 1'b0}));
        check_log("wr_full_access");
        check("sram_hw8", 32'(sram[8]), 32'h0000DEAD);
        check("sram_hw9", 32'(sram[9]), 32'h0000BEEF);

        wb_xfer(1'b0, 1'b0, 4, 4'hF, 32'h0, 0);
        exp_acc.push_back(acc_t'({18'h8, 1'b1, 1'b0, 1'b0, 1'b0}));
        exp_acc.push_back(acc_t'({18'h9, 1'b1, 1'b0, 1'b0, 1'b0}));
        check_log("rd_full_access");

        // Single low byte: only the second half-word, lower lane.
        wb_xfer(1'b0, 1'b1, 4, 4'b0001, 32'h000000AA, 0);
        exp_acc.push_back(acc_t'({18'h9, 1'b0, 1'b1, 1'b1, 1'b0}));
        check_log("wr_byte_access");
        check("sram_hw9_byte", 32'(sram[9]), 32'h0000BEAA);
        wb_xfer(1'b0, 1'b0, 4, 4'hF, 32'h0, 0);
        acc_log.delete();

        // Empty byte mask: immediate ack, no SRAM cycle.
        wb_xfer(1'b0, 1'b1, 4, 4'b0000, 32'h12345678, 0);
        check_log("wr_sel0_access");

        // Cycle dropped during the first read strobe.
        start_read_to_strobe("abort");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge sys_clk);
        #1;
        check("abort_ce_n",  32'(sram_ce_n),  32'd1);
        check("abort_oe_n",  32'(sram_oe_n),  32'd1);
        check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_ack",   32'(bus.s_ack),  32'd0);
        repeat (8) @(posedge sys_clk);
        wb_xfer(1'b0, 1'b0, 4, 4'hF, 32'h0, 0);

        // Asynchronous reset in the middle of a read strobe.
        start_read_to_strobe("midrst");
        #2;
        nreset = 1'b0;
        #1;
        check_reset_vals("midrst");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge sys_clk);
        #1;
        nreset = 1'b1;
        wb_xfer(1'b0, 1'b0, 4, 4'hF, 32'h0, 0);
        acc_log.delete();

        // Zero-wait-state device: two-half latency 5, one-half latency 3, sel=0 latency 1.
        wb_xfer(1'b1, 1'b1, 4, 4'hF, 32'h12345678, 0);
        wb_xfer(1'b1, 1'b0, 4, 4'hF, 32'h0, 0);
        wb_xfer(1'b1, 1'b1, 4, 4'b1000, 32'hA5000000, 0);
        wb_xfer(1'b1, 1'b1, 4, 4'b0000, 32'hFFFFFFFF, 0);
        wb_xfer(1'b1, 1'b0, 4, 4'hF, 32'h0, 0);

        // Prefill so every random read has a known word.
        for (int unsigned i = 0; i < 64; i++) wb_xfer(1'b0, 1'b1, i, 4'hF, $urandom, 0);
        for (int unsigned i = 0; i < 8; i++)  wb_xfer(1'b1, 1'b1, i, 4'hF, $urandom, 0);

        for (int unsigned n = 0; n < 250; n++)
            wb_xfer(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 4'($urandom_range(0, 15)),
                    $urandom, $urandom_range(0, 2));
        for (int unsigned n = 0; n < 30; n++)
            wb_xfer(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom_range(0, 15)),
                    $urandom, $urandom_range(0, 2));

        repeat (5) @(posedge sys_clk);
        if (sb.size() != 0 || sb_w0.size() != 0)
            check("scoreboard_drained", 32'(sb.size() + sb_w0.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
